imem_loader: RTL and testbench

Byte-stream program loader that fills the processor's byte-addressed instruction memory before execution. It accepts a framed byte stream over a valid/ready handshake: a 16-bit little-endian word count, the payload, and an XOR checksum. Payload bytes are written through a byte-wide write port, so instruction words land little-endian: word k, byte j goes to address BASE_ADDR + 4k + j. The CPU is held off via `cpu_hold` until a load completes cleanly.

---
 rtl/loader_pkg.sv | 23 ++
 rtl/imem_loader.sv | 124 ++++++++++++
 tb/tb_imem_loader.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and framing constants for the instruction-memory loader.
// The frame is a 2-byte length header, 4-byte payload words, then an XOR trailer.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int TRL_BYTES      = 1;
  localparam int BYTES_PER_WORD = 4;

  function automatic int frame_bytes(input int words);
    return HDR_BYTES + BYTES_PER_WORD * words + TRL_BYTES;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Byte-stream program loader: length header, payload written byte-wise to
// instruction memory, XOR checksum trailer; holds the CPU until a clean load.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  if (BASE_ADDR + BYTES_PER_WORD * MAX_WORDS > 2 ** ADDR_W) begin : g_size_chk
    $error("imem_loader: payload window exceeds address space");
  end

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t state, state_nx;

  logic [7:0]        len_lo;
  logic [15:0]       len;
  logic [ADDR_W-1:0] cnt;
  logic [7:0]        csum;

  logic        xfer;
  logic [15:0] len_in;
  logic        last_byte;
  logic        clr;
  logic        wr_fire;

  assign xfer   = byte_valid && byte_ready;
  assign len_in = {byte_data, len_lo};

  // Counter can never pass 4*LEN-1 in DATA, so equality is enough.
  assign last_byte = 32'(cnt) ==
    (32'(len) * 32'(BYTES_PER_WORD)) - 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    wr_fire  = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_nx = S_LEN_LO;
          clr      = 1'b1;
        end
      end
      S_LEN_LO: begin
        if (xfer) state_nx = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (xfer) begin
          if (len_in > 16'(MAX_WORDS)) state_nx = S_ERR;
          else if (len_in == 16'd0)    state_nx = S_CHECK;
          else                         state_nx = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          wr_fire = 1'b1;
          if (last_byte) state_nx = S_CHECK;
        end
      end
      S_CHECK: begin
        if (xfer) begin
          if (byte_data == csum) state_nx = S_DONE;
          else                   state_nx = S_ERR;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo  <= '0;
      len     <= '0;
      cnt     <= '0;
      csum    <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= wr_fire;
      if (clr) begin
        cnt  <= '0;
        csum <= '0;
      end
      if (state == S_LEN_LO && xfer) len_lo <= byte_data;
      if (state == S_LEN_HI && xfer) len    <= len_in;
      if (wr_fire) begin
        wr_addr <= BASE + cnt;
        wr_data <= byte_data;
        cnt     <= cnt + 1'b1;
        csum    <= csum ^ byte_data;
      end
    end
  end

  assign byte_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                      (state == S_DATA)   || (state == S_CHECK);
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERR);
  assign cpu_hold   = (state != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: vector table of frames plus gap,
// ignored-start and mid-load reset sequences against a byte memory model.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              cpu_hold;
  logic              done;
  logic              error;

  imem_loader #(
    .ADDR_W(ADDR_W),
    .BASE_ADDR(0),
    .MAX_WORDS(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .cpu_hold(cpu_hold),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [256];
  int         wr_cnt = 0;

  typedef struct {
    string       name;
    logic [15:0] len;
    int          npay;
    logic [95:0] pay;
    logic [7:0]  csum;
    bit          send_trl;
    bit          exp_done;
    bit          exp_err;
    int          exp_wr;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory model: writes must arrive in address order starting at BASE (0).
  always @(negedge clk) begin
    if (wr_en) begin
      chk("wr_addr_order", 32'(wr_addr), 32'(wr_cnt));
      mem[wr_addr] = wr_data;
      wr_cnt++;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    if (gap) repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    while (!ok && n < 50) begin
      ok = byte_ready;
      @(posedge clk);
      #1;
      n++;
    end
    byte_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input bit gap, input int start_at);
    for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
    wr_cnt = 0;
    pulse_start();
    chk({v.name, "_ready_after_start"}, 32'(byte_ready), 32'd1);
    chk({v.name, "_status_clear"}, {30'd0, done, error}, 32'd0);
    send_byte(v.len[7:0], gap);
    send_byte(v.len[15:8], gap);
    for (int i = 0; i < v.npay; i++) begin
      send_byte(v.pay[8*i +: 8], gap);
      if (i == start_at) begin
        pulse_start();
        chk({v.name, "_start_ignored"}, 32'(byte_ready), 32'd1);
      end
    end
    if (v.send_trl) send_byte(v.csum, gap);
    chk({v.name, "_done"}, 32'(done), 32'(v.exp_done));
    chk({v.name, "_error"}, 32'(error), 32'(v.exp_err));
    chk({v.name, "_cpu_hold"}, 32'(cpu_hold), 32'(!v.exp_done));
    @(negedge clk);
    chk({v.name, "_wr_count"}, 32'(wr_cnt), 32'(v.exp_wr));
    chk({v.name, "_ready_low"}, 32'(byte_ready), 32'd0);
    for (int i = 0; i < v.exp_wr; i++)
      chk({v.name, "_mem"}, 32'(mem[i]), 32'(v.pay[8*i +: 8]));
    repeat (2) @(negedge clk);
    chk({v.name, "_no_extra_wr"}, 32'(wr_cnt), 32'(v.exp_wr));
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{"good3", 16'd3, 12,
      {8'h00, 8'h90, 8'h05, 8'h13, 8'h00, 8'h00, 8'h00, 8'h73,
       8'h00, 8'hA0, 8'h05, 8'h13},
      8'h43, 1'b1, 1'b1, 1'b0, 12};
    vecs[1] = '{"empty_ok", 16'd0, 0, 96'd0, 8'h00, 1'b1, 1'b1, 1'b0, 0};
    vecs[2] = '{"empty_bad", 16'd0, 0, 96'd0, 8'h5A, 1'b1, 1'b0, 1'b1, 0};
    vecs[3] = '{"oversize65", 16'd65, 0, 96'd0, 8'h00, 1'b0, 1'b0, 1'b1, 0};
    vecs[4] = '{"bad_csum", 16'd1, 4,
      {64'd0, 8'h04, 8'h03, 8'h02, 8'h01},
      8'h00, 1'b1, 1'b0, 1'b1, 4};
    vecs[5] = '{"oversize256", 16'h0100, 0, 96'd0, 8'h00, 1'b0, 1'b0, 1'b1, 0};

    #12;
    chk("rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_done_error", {30'd0, done, error}, 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[k]) begin
      run_vec(vecs[k], 1'b0, -1);
      if (k == 0)
        chk("good3_word0", {mem[3], mem[2], mem[1], mem[0]}, 32'h00A00513);
    end

    // Same frame with random gaps and a start pulse in the middle of DATA.
    run_vec(vecs[0], 1'b1, 5);
    chk("gaps_word2", {mem[11], mem[10], mem[9], mem[8]}, 32'h00900513);

    // Asynchronous reset after the fifth of eight payload bytes.
    begin
      int n;
      wr_cnt = 0;
      pulse_start();
      send_byte(8'd2, 1'b0);
      send_byte(8'd0, 1'b0);
      for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i), 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midrst_wr_en", 32'(wr_en), 32'd0);
      chk("midrst_wr_addr_data", {16'd0, wr_addr, wr_data}, 32'd0);
      chk("midrst_ready", 32'(byte_ready), 32'd0);
      chk("midrst_status", {29'd0, cpu_hold, done, error}, 32'd4);
      n = wr_cnt;
      repeat (3) @(negedge clk);
      chk("midrst_no_wr", 32'(wr_cnt), 32'(n));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
    end
    run_vec(vecs[0], 1'b0, -1);
    chk("after_rst_word1", {mem[7], mem[6], mem[5], mem[4]}, 32'h00000073);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
